hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_scoreboard_fwd_select.sv | 25 ++
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard scoreboard: forwarding
// select codes and the multiplier sequencer state.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mulState_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// One Execute operand's bypass select: the Memory-stage writer is younger, so it
// wins over Writeback; register 0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rdM,
  input  logic             regwriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regwriteW,
  output logic [1:0]       fwdSel
);

  always_comb begin
    fwdSel = FWD_REG;
    if (regwriteM && (rdM != '0) && (rdM == rsE)) begin
      fwdSel = FWD_M;
    end else if (regwriteW && (rdW != '0) && (rdW == rsE)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline with a multi-cycle multiplier: operand
// forwarding, load-use and multiplier stalls, branch flushes, multiplier tracking.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic [REG_W-1:0] rdD,
  input  logic             regwriteD,
  input  logic             mul_opD,
  input  logic [REG_W-1:0] rs1E,
  input  logic [REG_W-1:0] rs2E,
  input  logic [REG_W-1:0] rdE,
  input  logic             regwriteE,
  input  logic             memreadE,
  input  logic             mul_startE,
  input  logic             pcsrcE,
  input  logic [REG_W-1:0] rdM,
  input  logic             regwriteM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regwriteW,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [REG_W-1:0] mul_rd
);

  localparam int CNT_W = $clog2(MUL_LAT);

  mulState_t           stateReg;
  logic [CNT_W-1:0]    cntReg;
  logic [REG_W-1:0]    mulRdReg;
  logic                doneReg;

  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic       loadUse;
  logic       mulDepE;
  logic       mulDepBusy;
  logic       mulStruct;
  logic       stall;

  fwd_select #(.REG_W(REG_W)) uFwdA (
    .rsE(rs1E), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .fwdSel(fwdA)
  );

  fwd_select #(.REG_W(REG_W)) uFwdB (
    .rsE(rs2E), .rdM(rdM), .regwriteM(regwriteM),
    .rdW(rdW), .regwriteW(regwriteW), .fwdSel(fwdB)
  );

  assign mul_busy = (stateReg == BUSY);
  assign mul_done = doneReg;
  assign mul_rd   = mulRdReg;

  always_comb begin
    loadUse    = memreadE && regwriteE && (rdE != '0) &&
                 ((rdE == rs1D) || (rdE == rs2D));
    // A destination match also counts so a younger write cannot be overtaken.
    mulDepE    = mul_startE && (rdE != '0) &&
                 ((rdE == rs1D) || (rdE == rs2D) || (regwriteD && (rdE == rdD)));
    mulDepBusy = mul_busy && (mulRdReg != '0) &&
                 ((mulRdReg == rs1D) || (mulRdReg == rs2D) ||
                  (regwriteD && (mulRdReg == rdD)));
    mulStruct  = mul_opD && (mul_startE || mul_busy);
    stall      = loadUse || mulDepE || mulDepBusy || mulStruct;
  end

  always_comb begin
    forwardaE = FWD_REG;
    forwardbE = FWD_REG;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    if (!rst) begin
      forwardaE = fwdA;
      forwardbE = fwdB;
      // A taken branch discards the stalled instruction anyway, so it wins.
      if (pcsrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      mulRdReg <= '0;
      doneReg  <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          doneReg <= 1'b0;
          if (mul_startE) begin
            stateReg <= BUSY;
            cntReg   <= CNT_W'(MUL_LAT - 1);
            mulRdReg <= rdE;
          end
        end
        BUSY: begin
          if (cntReg == '0) begin
            stateReg <= IDLE;
            doneReg  <= 1'b0;
          end else begin
            cntReg  <= cntReg - 1'b1;
            doneReg <= (cntReg == CNT_W'(1));
          end
        end
        default: begin
          stateReg <= IDLE;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end

  // A start while busy is dropped; the structural stall should make it impossible.
  assert property (@(posedge clk) disable iff (rst) !(mul_startE && stateReg == BUSY));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized plus directed checks of hazard_scoreboard against a cycle-numbered
// behavioural model of the multiplier occupancy and the hazard rules.
module tb_hazard_scoreboard;

  localparam int REG_W   = 5;
  localparam int MUL_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW;
  logic regwriteD, mul_opD, regwriteE, memreadE, mul_startE, pcsrcE;
  logic regwriteM, regwriteW;
  logic [1:0] forwardaE, forwardbE;
  logic stallF, stallD, flushD, flushE, mul_busy, mul_done;
  logic [REG_W-1:0] mul_rd;

  int total = 0;
  int bad   = 0;

  // Model: an in-flight multiply is described by the cycle its result is due.
  int cyc = 0;
  bit mActive = 1'b0;
  int mEnd = 0;
  logic [REG_W-1:0] mRd = '0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(REG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .regwriteD(regwriteD), .mul_opD(mul_opD),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE),
    .mul_startE(mul_startE), .pcsrcE(pcsrcE),
    .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW), .regwriteW(regwriteW),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_rd(mul_rd)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] expFwd(input logic [REG_W-1:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit readsOrWrites(input logic [REG_W-1:0] r);
    return (r != 0) && (r == rs1D || r == rs2D || (regwriteD && r == rdD));
  endfunction

  function automatic bit modelBusy();
    return mActive && (cyc <= mEnd);
  endfunction

  // Inputs are already set; check at the falling edge, then advance the model.
  task automatic runCycle();
    bit busyX, doneX, stallX;
    @(negedge clk);
    busyX  = modelBusy();
    doneX  = busyX && (cyc == mEnd);
    stallX = (memreadE && regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D)) ||
             (mul_startE && readsOrWrites(rdE)) ||
             (busyX && readsOrWrites(mRd)) ||
             (mul_opD && (mul_startE || busyX));
    checkEq("fwdA",   forwardaE, rst ? 2'b00 : expFwd(rs1E));
    checkEq("fwdB",   forwardbE, rst ? 2'b00 : expFwd(rs2E));
    checkEq("stallF", stallF, !rst && !pcsrcE && stallX);
    checkEq("stallD", stallD, !rst && !pcsrcE && stallX);
    checkEq("flushD", flushD, !rst && pcsrcE);
    checkEq("flushE", flushE, !rst && (pcsrcE || stallX));
    checkEq("busy",   mul_busy, busyX);
    checkEq("done",   mul_done, doneX);
    checkEq("mulRd",  mul_rd, mRd);
    @(posedge clk);
    if (rst) begin
      mActive = 1'b0;
      mRd     = '0;
    end else if (!busyX && mul_startE) begin
      mActive = 1'b1;
      mEnd    = cyc + 1 + MUL_LAT - 1;
      mRd     = rdE;
    end else if (doneX) begin
      mActive = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic clearInputs();
    rst = 1'b0;
    {rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteD, mul_opD, regwriteE, memreadE, mul_startE, pcsrcE, regwriteM, regwriteW} = '0;
  endtask

  task automatic randomInputs();
    clearInputs();
    rst  = ($urandom_range(0, 39) == 0);
    rs1D = REG_W'($urandom_range(0, 3)); rs2D = REG_W'($urandom_range(0, 3));
    rdD  = REG_W'($urandom_range(0, 3)); rs1E = REG_W'($urandom_range(0, 3));
    rs2E = REG_W'($urandom_range(0, 3)); rdE  = REG_W'($urandom_range(0, 3));
    rdM  = REG_W'($urandom_range(0, 3)); rdW  = REG_W'($urandom_range(0, 3));
    regwriteD = 1'($urandom); mul_opD = ($urandom_range(0, 2) == 0);
    regwriteE = 1'($urandom); memreadE = ($urandom_range(0, 2) == 0);
    pcsrcE    = ($urandom_range(0, 7) == 0);
    regwriteM = 1'($urandom); regwriteW = 1'($urandom);
    mul_startE = !modelBusy() && ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    clearInputs();
    rst = 1'b1;
    #1;
    runCycle();
    runCycle();
    rst = 1'b0;

    // Forwarding priority, then register 0 never forwarded.
    regwriteM = 1; rdM = 5; rs1E = 5; regwriteW = 1; rdW = 5; rs2E = 5;
    runCycle();
    checkEq("fwdA_M", forwardaE, 2'b10);
    rdM = 0; rdW = 0;
    runCycle();
    checkEq("fwdB_zero", forwardbE, 2'b00);

    // Load-use stall, then branch override.
    clearInputs();
    memreadE = 1; regwriteE = 1; rdE = 7; rs2D = 7;
    runCycle();
    checkEq("loadUse_stallD", stallD, 1'b1);
    pcsrcE = 1;
    runCycle();
    checkEq("branch_stallF", stallF, 1'b0);

    // Dependent multiply: stall through the done cycle, then release.
    clearInputs();
    rs1D = 9; rdE = 9; mul_startE = 1;
    runCycle();
    mul_startE = 0; rdE = 0;
    for (int i = 0; i < MUL_LAT + 2; i++) runCycle();

    // Reset in the middle of a multiply discards it.
    clearInputs();
    rs1D = 9; rdE = 9; mul_startE = 1;
    runCycle();
    mul_startE = 0; rdE = 0;
    runCycle();
    rst = 1;
    runCycle();
    rst = 0;
    for (int i = 0; i < MUL_LAT + 1; i++) runCycle();

    // Back-to-back multiplies: the second issues right after the first completes.
    clearInputs();
    mul_opD = 1; rdE = 3; mul_startE = 1;
    runCycle();
    for (int i = 0; i < 2 * MUL_LAT + 2; i++) begin
      mul_startE = !modelBusy() && (i < MUL_LAT + 1);
      rdE = 4;
      runCycle();
    end

    // Multiply to r0: no data stall, but a structural one for a second multiply.
    clearInputs();
    rdE = 0; mul_startE = 1;
    runCycle();
    mul_startE = 0; rs1D = 0;
    runCycle();
    checkEq("r0_nodep", stallD, 1'b0);
    mul_opD = 1;
    runCycle();
    checkEq("r0_struct", stallD, 1'b1);
    clearInputs();
    for (int i = 0; i < MUL_LAT; i++) runCycle();

    for (int i = 0; i < 800; i++) begin
      randomInputs();
      runCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
